// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning block.
// Imported by the per-channel debouncer and by the top-level wrapper.
package btn_pkg;

    // The encoding is visible on debug_state, so it is fixed explicitly.
    typedef enum logic [1:0] {
        ST_LO      = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_WAIT_LO = 2'd3
    } btn_state_t;

    // 10 ms of stability at 125 MHz.
    localparam int DEBOUNCE_DEFAULT = 1_250_000;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button-side bundle: raw pins in, debounced level/pulses and FSM debug out.
// The master side drives the raw pins; the slave side is the conditioner.
interface btn_conditioner_if #(
    parameter int N_BTN = 4
);

    logic [N_BTN-1:0]   btn_raw;
    logic [N_BTN-1:0]   btn_level;
    logic [N_BTN-1:0]   btn_press;
    logic [N_BTN-1:0]   btn_release;
    logic [2*N_BTN-1:0] debug_state;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  debug_state
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output debug_state
    );

endinterface

// File: rtl/btn_debounce.sv
// Single button channel: 2-flop synchroniser, debounce FSM with a qualification
// counter, and registered level / press / release outputs.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_raw,
    output logic       o_level,
    output logic       o_press,
    output logic       o_release,
    output btn_state_t o_state
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source; blocking here would collapse the 2-flop chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Saturating increment; the count never wraps back into a qualifying value.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;

        case (r_state)
            ST_LO: begin
                if (r_sync2) begin
                    w_state_nxt = ST_WAIT_HI;
                    w_cnt_nxt   = '0;
                end
            end

            ST_WAIT_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_LO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_HI;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            ST_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_WAIT_LO;
                    w_cnt_nxt   = '0;
                end
            end

            ST_WAIT_LO: begin
                if (r_sync2) begin
                    w_state_nxt = ST_HI;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = ST_LO;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            default: begin
                w_state_nxt = ST_LO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_LO;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_state   = r_state;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced levels and press/release
// pulses; one independent btn_debounce per channel.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    btn_conditioner_if.slave   bus
);

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;
    btn_state_t       w_state [N_BTN];

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .i_btn_raw (bus.btn_raw[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_state   (w_state[g])
        );

        // Channel g reports its FSM state in debug_state[2g+1:2g].
        assign bus.debug_state[2*g +: 2] = w_state[g];
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;

endmodule
